counter_4bit_down_reload: RTL and testbench

//  Loadable synchronous down counter (timer) with terminal-count detect.

---
 rtl/counter_4bit_down_reload_pkg.sv | 15 +
 rtl/counter_4bit_down_reload.sv | 71 +++++++
 tb/tb_counter_4bit_down_reload.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/counter_4bit_down_reload_pkg.sv
// rtl/counter_4bit_down_reload_pkg.sv - shared types and constants for the down-counter timer
package counter_4bit_down_reload_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // IDLE holds the count; RUN decrements on enabled edges
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_4bit_down_reload.sv
// rtl/counter_4bit_down_reload.sv - loadable down counter with one-shot/periodic reload and terminal-count pulse
module counter_4bit_down_reload
   import counter_4bit_down_reload_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_n;
   logic [WIDTH-1:0] reload, reload_n;
   logic [WIDTH-1:0] count_n;
   logic             tc_n;

   // Registers for state, count, reload value and the terminal-count pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         count  <= ZERO;
         reload <= ZERO;
         tc     <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         reload <= reload_n;
         tc     <= tc_n;
      end
   end

   // Next-state logic: load beats decrement beats hold; tc only follows a 1->0 step
   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      tc_n     = 1'b0;
      if (load) begin
         count_n  = data_in;
         reload_n = data_in;
         state_n  = (data_in != ZERO) ? ST_RUN : ST_IDLE;
      end else if (en && (state == ST_RUN)) begin
         if (count > ONE) begin
            count_n = count - ONE;
         end else if (count == ONE) begin
            count_n = ZERO;
            tc_n    = 1'b1;
            state_n = (mode == MODE_PERIODIC) ? ST_RUN : ST_IDLE;
         end else begin
            // Sitting at zero in RUN only happens after a periodic 1->0 step,
            // so restart from the stored value; mode is only consulted at 1->0.
            count_n = reload;
         end
      end
   end

   // busy is a pure decode of the state register
   always_comb begin
      busy = (state == ST_RUN);
   end

endmodule

// File: tb/tb_counter_4bit_down_reload.sv
// tb/tb_counter_4bit_down_reload.sv - scoreboard bench for the down-counter timer
`timescale 1ns/1ps
module tb_counter_4bit_down_reload;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] data_in;
   logic       mode;
   logic [3:0] count;
   logic       tc;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int step_idx = 0;
   logic [5:0] exp_q[$];
   int         tag_q[$];

   counter_4bit_down_reload #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .data_in (data_in),
      .mode    (mode),
      .count   (count),
      .tc      (tc),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_now(input string name, input logic [3:0] ec, input logic et, input logic eb);
      checks++;
      if (count !== ec || tc !== et || busy !== eb) begin
         failures++;
         $display("FAIL %s: got count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                  name, count, tc, busy, ec, et, eb);
      end
   endtask

   // Drive inputs on the falling edge and queue the outputs expected after the next rising edge
   task automatic step(input logic e, input logic l, input logic [3:0] d, input logic m,
                       input logic [3:0] ec, input logic et, input logic eb);
      @(negedge clk);
      en      = e;
      load    = l;
      data_in = d;
      mode    = m;
      exp_q.push_back({ec, et, eb});
      tag_q.push_back(step_idx);
      step_idx++;
   endtask

   // Monitor: after each rising edge, compare against the oldest queued expectation
   always @(posedge clk) begin
      logic [5:0] e;
      int         t;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (count !== e[5:2] || tc !== e[1] || busy !== e[0]) begin
            failures++;
            $display("FAIL step%0d: got count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                     t, count, tc, busy, e[5:2], e[1], e[0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; data_in = 4'd0; mode = 1'b0;
      #1;
      check_now("reset_at_time0", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // One-shot from 13
      step(0, 1, 4'd13, 0, 4'd13, 0, 1);
      for (int i = 12; i >= 1; i--) step(1, 0, 4'd0, 0, 4'(i), 0, 1);
      step(1, 0, 4'd0, 0, 4'd0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 4'd0, 0, 4'd0, 0, 0);

      // Periodic reload of 3: period of 4 enabled edges
      step(0, 1, 4'd3, 1, 4'd3, 0, 1);
      for (int r = 0; r < 2; r++) begin
         step(1, 0, 4'd0, 1, 4'd2, 0, 1);
         step(1, 0, 4'd0, 1, 4'd1, 0, 1);
         step(1, 0, 4'd0, 1, 4'd0, 1, 1);
         step(1, 0, 4'd0, 1, 4'd3, 0, 1);
      end

      // Stall at 2 and at 0
      step(0, 1, 4'd5, 1, 4'd5, 0, 1);
      step(1, 0, 4'd0, 1, 4'd4, 0, 1);
      step(1, 0, 4'd0, 1, 4'd3, 0, 1);
      step(1, 0, 4'd0, 1, 4'd2, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 1, 4'd2, 0, 1);
      step(1, 0, 4'd0, 1, 4'd1, 0, 1);
      step(1, 0, 4'd0, 1, 4'd0, 1, 1);
      step(0, 0, 4'd0, 1, 4'd0, 0, 1);
      step(0, 0, 4'd0, 1, 4'd0, 0, 1);
      step(1, 0, 4'd0, 1, 4'd5, 0, 1);

      // Load priority over enable, restart in RUN, load of zero
      step(0, 1, 4'd7, 1, 4'd7, 0, 1);
      step(1, 1, 4'd5, 1, 4'd5, 0, 1);
      step(1, 0, 4'd0, 1, 4'd4, 0, 1);
      step(1, 1, 4'd0, 1, 4'd0, 0, 0);
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);

      // Mode switched to one-shot mid-run applies at the 1->0 step
      step(0, 1, 4'd2, 1, 4'd2, 0, 1);
      step(1, 0, 4'd0, 1, 4'd1, 0, 1);
      step(1, 0, 4'd0, 0, 4'd0, 1, 0);
      step(1, 0, 4'd0, 0, 4'd0, 0, 0);

      // Maximum load value holds while disabled
      step(0, 1, 4'd15, 0, 4'd15, 0, 1);
      step(0, 0, 4'd0, 0, 4'd15, 0, 1);
      step(1, 0, 4'd0, 0, 4'd14, 0, 1);

      // Asynchronous reset between edges while running periodic at 9
      step(0, 1, 4'd9, 1, 4'd9, 0, 1);
      @(negedge clk);
      en = 1'b1; load = 1'b0; mode = 1'b1;
      rst = 1'b1;
      #2;
      check_now("async_reset_mid_run", 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 1, 4'd0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
